// File: rtl/rf_bram_ctrl.sv
// Register-file BRAM controller: post-reset clear, write-port arbitration, x0 suppression.
// Optional same-cycle write-to-read bypass enabled by defining RF_BYPASS_EN.
module rf_bram_ctrl #(
  parameter int unsigned DTW     = 32,
  parameter int unsigned DPT     = 32,
  parameter int unsigned ZERO_R0 = 1,
  localparam int unsigned ADW    = $clog2(DPT),
  localparam int unsigned DPT_2N = 2 ** ADW
) (
  input  logic           clk,
  input  logic           aresetn,
  input  logic           i_wb_wren,
  input  logic [ADW-1:0] i_wb_waddr,
  input  logic [DTW-1:0] i_wb_wdata,
  input  logic           i_aux_wvalid,
  output logic           o_aux_wready,
  input  logic [ADW-1:0] i_aux_waddr,
  input  logic [DTW-1:0] i_aux_wdata,
  input  logic           i_rden,
  input  logic [ADW-1:0] i_raddr0,
  input  logic [ADW-1:0] i_raddr1,
  output logic [DTW-1:0] o_rdata0,
  output logic [DTW-1:0] o_rdata1,
  output logic           o_busy,
  output logic           o_bram_wren,
  output logic [ADW-1:0] o_bram_waddr,
  output logic [DTW-1:0] o_bram_wdata,
  output logic           o_bram_rden,
  output logic [ADW-1:0] o_bram_raddr0,
  output logic [ADW-1:0] o_bram_raddr1,
  input  logic [DTW-1:0] i_bram_rdata0,
  input  logic [DTW-1:0] i_bram_rdata1
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [ADW:0] ClrLast = (ADW+1)'(DPT_2N - 1);

  state_e       state_q, state_d;
  logic [ADW:0] clr_cnt_q, clr_cnt_d;
  logic         wr_req;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StInit;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    o_busy       = 1'b0;
    o_aux_wready = 1'b0;
    o_bram_wren  = 1'b0;
    o_bram_waddr = '0;
    o_bram_wdata = '0;
    o_bram_rden  = 1'b0;
    wr_req       = 1'b0;
    case (state_q)
      StInit: begin
        // Requests arriving during the clear are dropped, not queued.
        o_busy       = 1'b1;
        o_bram_wren  = 1'b1;
        o_bram_waddr = clr_cnt_q[ADW-1:0];
        clr_cnt_d    = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ClrLast) state_d = StRun;
      end
      StRun: begin
        o_bram_rden = i_rden;
        if (i_wb_wren) begin
          wr_req       = 1'b1;
          o_bram_waddr = i_wb_waddr;
          o_bram_wdata = i_wb_wdata;
        end else begin
          o_aux_wready = 1'b1;
          wr_req       = i_aux_wvalid;
          o_bram_waddr = i_aux_waddr;
          o_bram_wdata = i_aux_wdata;
        end
        // x0 writes are swallowed; the aux handshake still completes.
        o_bram_wren = wr_req && !((ZERO_R0 != 0) && (o_bram_waddr == '0));
      end
      default: state_d = StInit;
    endcase
  end

  assign o_bram_raddr0 = i_raddr0;
  assign o_bram_raddr1 = i_raddr1;

`ifdef RF_BYPASS_EN
  logic           byp_vld0_q, byp_vld1_q;
  logic [DTW-1:0] byp_data0_q, byp_data1_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      byp_vld0_q  <= 1'b0;
      byp_vld1_q  <= 1'b0;
      byp_data0_q <= '0;
      byp_data1_q <= '0;
    end else if (o_bram_rden) begin
      byp_vld0_q  <= o_bram_wren && (o_bram_waddr == i_raddr0);
      byp_vld1_q  <= o_bram_wren && (o_bram_waddr == i_raddr1);
      byp_data0_q <= o_bram_wdata;
      byp_data1_q <= o_bram_wdata;
    end
  end

  assign o_rdata0 = byp_vld0_q ? byp_data0_q : i_bram_rdata0;
  assign o_rdata1 = byp_vld1_q ? byp_data1_q : i_bram_rdata1;
`else
  assign o_rdata0 = i_bram_rdata0;
  assign o_rdata1 = i_bram_rdata1;
`endif

endmodule

// File: tb/tb_rf_bram_ctrl.sv
// Bench for rf_bram_ctrl with a read-first 2R1W BRAM model, directed table and random traffic.
module tb_rf_bram_ctrl;

`ifdef RF_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        aresetn;
  logic        wb_wren, aux_wvalid, aux_wready, rden;
  logic [4:0]  wb_waddr, aux_waddr, raddr0, raddr1;
  logic [31:0] wb_wdata, aux_wdata, rdata0, rdata1;
  logic        busy, bram_wren, bram_rden;
  logic [4:0]  bram_waddr, bram_raddr0, bram_raddr1;
  logic [31:0] bram_wdata, bram_rdata0, bram_rdata1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_bram_ctrl #(.DTW(32), .DPT(32), .ZERO_R0(1)) dut (
    .clk(clk), .aresetn(aresetn),
    .i_wb_wren(wb_wren), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
    .i_aux_wvalid(aux_wvalid), .o_aux_wready(aux_wready),
    .i_aux_waddr(aux_waddr), .i_aux_wdata(aux_wdata),
    .i_rden(rden), .i_raddr0(raddr0), .i_raddr1(raddr1),
    .o_rdata0(rdata0), .o_rdata1(rdata1), .o_busy(busy),
    .o_bram_wren(bram_wren), .o_bram_waddr(bram_waddr), .o_bram_wdata(bram_wdata),
    .o_bram_rden(bram_rden), .o_bram_raddr0(bram_raddr0), .o_bram_raddr1(bram_raddr1),
    .i_bram_rdata0(bram_rdata0), .i_bram_rdata1(bram_rdata1)
  );

  // Read-first BRAM; junk port lets the bench scribble memory before the clear.
  logic [31:0] mem [32];
  logic        junk_we = 1'b0;
  logic [4:0]  junk_a = '0;
  logic [31:0] junk_d = '0;
  always @(posedge clk) begin
    if (bram_rden) begin
      bram_rdata0 <= mem[bram_raddr0];
      bram_rdata1 <= mem[bram_raddr1];
    end
    if (junk_we) mem[junk_a] <= junk_d;
    else if (bram_wren) mem[bram_waddr] <= bram_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_wren = 0; wb_waddr = 0; wb_wdata = 0;
    aux_wvalid = 0; aux_waddr = 0; aux_wdata = 0;
    rden = 0; raddr0 = 0; raddr1 = 0;
  endtask

  // Called at a negedge: releases reset and follows the whole clear sequence.
  task automatic release_and_check();
    aresetn = 1'b1;
    for (int k = 0; k < 32; k++) begin
      wb_wren = 1; wb_waddr = 5'd3; wb_wdata = 32'hBAD0_0003;
      aux_wvalid = 1; aux_waddr = 5'd4; aux_wdata = 32'hBAD0_0004;
      rden = 1;
      #1;
      chk("init_ctl", {28'd0, busy, bram_wren, aux_wready, bram_rden}, 32'hC);
      chk("init_waddr", {27'd0, bram_waddr}, k);
      chk("init_wdata", bram_wdata, 32'd0);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("clear_done_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic read_sweep();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rden = 1; raddr0 = 5'(i); raddr1 = 5'(31 - i);
      @(posedge clk); #1;
      chk("sweep_r0", rdata0, 32'd0);
      chk("sweep_r1", rdata1, 32'd0);
    end
    @(negedge clk);
    rden = 0;
  endtask

  typedef struct {
    logic        wb_we; logic [4:0] wb_a; logic [31:0] wb_d;
    logic        ax_v;  logic [4:0] ax_a; logic [31:0] ax_d;
    logic        re;    logic [4:0] r0;   logic [4:0]  r1;
    logic        e_rdy; logic       e_we; logic [4:0]  e_wa;
    logic [31:0] e_r0_old, e_r1_old, e_r0_new, e_r1_new;
  } vec_t;

  vec_t vecs[12];

  logic [31:0] ref_mem [32];
  logic [31:0] exp_r0, exp_r1;

  initial begin
    logic [31:0] e0, e1;
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0, 0, 0, 1, 5,  0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0,            0, 0, 0,     1, 5, 6, 1, 0, 0,  32'hDEADBEEF, 0,
                 32'hDEADBEEF, 0};
    vecs[2]  = '{1, 7, 32'h1234,     0, 0, 0,     1, 7, 7, 0, 1, 7,  0, 0, 32'h1234, 32'h1234};
    vecs[3]  = '{1, 3, 32'h11,       1, 9, 32'hA5, 0, 0, 0, 0, 1, 3, 0, 0, 32'h1234, 32'h1234};
    vecs[4]  = '{0, 0, 0,            1, 9, 32'hA5, 0, 0, 0, 1, 1, 9, 0, 0, 32'h1234, 32'h1234};
    vecs[5]  = '{0, 0, 0,            0, 0, 0,     1, 9, 3, 1, 0, 0,  32'hA5, 32'h11, 32'hA5, 32'h11};
    vecs[6]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,     0, 0, 0, 0, 0, 0,  32'hA5, 32'h11, 32'hA5, 32'h11};
    vecs[7]  = '{0, 0, 0,            0, 0, 0,     1, 0, 7, 1, 0, 0,  0, 32'h1234, 0, 32'h1234};
    vecs[8]  = '{0, 0, 0,            1, 0, 32'h77, 0, 0, 0, 1, 0, 0, 0, 32'h1234, 0, 32'h1234};
    vecs[9]  = '{0, 0, 0,            0, 0, 0,     0, 5, 9, 1, 0, 0,  0, 32'h1234, 0, 32'h1234};
    vecs[10] = '{0, 0, 0,            1, 5, 32'hCAFE, 1, 5, 9, 1, 1, 5, 32'hDEADBEEF, 32'hA5,
                 32'hCAFE, 32'hA5};
    vecs[11] = '{0, 0, 0,            0, 0, 0,     1, 5, 7, 1, 0, 0,  32'hCAFE, 32'h1234,
                 32'hCAFE, 32'h1234};

    idle_inputs();
    aresetn = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ctl", {29'd0, bram_wren, aux_wready, bram_rden}, 32'h4);
    chk("rst_waddr_wdata", {27'd0, bram_waddr} | bram_wdata, 32'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      junk_we = 1; junk_a = 5'(i); junk_d = $urandom | 32'h1;
    end
    @(negedge clk);
    junk_we = 0;
    chk("rst_held_busy", {31'd0, busy}, 32'd1);

    release_and_check();
    read_sweep();

    // Directed table
    foreach (vecs[i]) begin
      @(negedge clk);
      wb_wren = vecs[i].wb_we; wb_waddr = vecs[i].wb_a; wb_wdata = vecs[i].wb_d;
      aux_wvalid = vecs[i].ax_v; aux_waddr = vecs[i].ax_a; aux_wdata = vecs[i].ax_d;
      rden = vecs[i].re; raddr0 = vecs[i].r0; raddr1 = vecs[i].r1;
      #1;
      chk($sformatf("v%0d_rdy", i), {31'd0, aux_wready}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_we", i), {31'd0, bram_wren}, {31'd0, vecs[i].e_we});
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_wa", i), {27'd0, bram_waddr}, {27'd0, vecs[i].e_wa});
        chk($sformatf("v%0d_wd", i), bram_wdata, vecs[i].wb_we ? vecs[i].wb_d : vecs[i].ax_d);
      end
      @(posedge clk); #1;
      e0 = Byp ? vecs[i].e_r0_new : vecs[i].e_r0_old;
      e1 = Byp ? vecs[i].e_r1_new : vecs[i].e_r1_old;
      chk($sformatf("v%0d_rd0", i), rdata0, e0);
      chk($sformatf("v%0d_rd1", i), rdata1, e1);
    end

    // Random traffic against an array-based reference
    for (int a = 0; a < 32; a++) ref_mem[a] = 32'd0;
    ref_mem[5] = 32'hCAFE; ref_mem[7] = 32'h1234; ref_mem[9] = 32'hA5; ref_mem[3] = 32'h11;
    exp_r0 = 32'hCAFE; exp_r1 = 32'h1234;
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      logic       wr, rdy_e;
      logic [4:0] wa;
      logic [31:0] wd;
      @(negedge clk);
      wb_wren = ($urandom_range(0, 2) == 0);
      wb_waddr = 5'($urandom_range(0, 7)); wb_wdata = $urandom;
      if (!aux_wvalid && ($urandom_range(0, 1) == 1)) begin
        aux_wvalid = 1; aux_waddr = 5'($urandom_range(0, 7)); aux_wdata = $urandom;
      end
      rden = ($urandom_range(0, 3) != 0);
      raddr0 = 5'($urandom_range(0, 7)); raddr1 = 5'($urandom_range(0, 7));
      rdy_e = !wb_wren;
      wr = wb_wren || aux_wvalid;
      wa = wb_wren ? wb_waddr : aux_waddr;
      wd = wb_wren ? wb_wdata : aux_wdata;
      if (wa == 5'd0) wr = 1'b0;
      #1;
      chk("rnd_rdy", {31'd0, aux_wready}, {31'd0, rdy_e});
      chk("rnd_we", {31'd0, bram_wren}, {31'd0, wr});
      if (wr) chk("rnd_waddr_wdata", bram_wdata ^ {27'd0, bram_waddr}, wd ^ {27'd0, wa});
      if (rden) begin
        exp_r0 = (Byp && wr && wa == raddr0) ? wd : ref_mem[raddr0];
        exp_r1 = (Byp && wr && wa == raddr1) ? wd : ref_mem[raddr1];
      end
      if (wr) ref_mem[wa] = wd;
      @(posedge clk); #1;
      chk("rnd_rd0", rdata0, exp_r0);
      chk("rnd_rd1", rdata1, exp_r1);
      if (aux_wvalid && rdy_e) aux_wvalid = 0;
    end

    // Reset pulsed mid-clear restarts the sequence from address 0
    @(negedge clk);
    idle_inputs();
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    for (int k = 0; k < 10; k++) @(negedge clk);
    #1;
    chk("mid_waddr10", {27'd0, bram_waddr}, 32'd10);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_waddr", {27'd0, bram_waddr}, 32'd0);
    @(negedge clk);
    release_and_check();
    read_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
